// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and result-flag bit positions for the ALU command sequencer.
package alu_seq_pkg;
   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_LOADA   = 4'd1;
   localparam logic [3:0] OP_LOADB   = 4'd2;
   localparam logic [3:0] OP_READOUT = 4'd3;
   localparam logic [3:0] OP_ADD     = 4'd4;
   localparam logic [3:0] OP_SUB     = 4'd5;

   localparam int FLAG_C = 10;
   localparam int FLAG_S = 9;
   localparam int FLAG_V = 8;

   typedef enum logic [2:0] {IDLE, LDA, LDB, EXE, RDO, WAIT, RSP} state_t;

   // Opcodes 0..3 are reserved for sequencer-generated commands.
   function automatic logic op_legal(input logic [3:0] op);
      return op >= OP_ADD;
   endfunction
endpackage

// File: rtl/alu_seq_opcache.sv
// Last-loaded operand cache so repeated operands skip their LOAD command.
// Only present when ALU_SEQ_SKIP_RELOAD_EN is defined.
`ifdef ALU_SEQ_SKIP_RELOAD_EN
module alu_seq_opcache #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] cmp_a,
   input  logic [DW-1:0] cmp_b,
   input  logic          ld_a,
   input  logic          ld_b,
   input  logic [DW-1:0] ld_b_data,
   input  logic          clr,
   output logic          hit_a,
   output logic          hit_b
);
   logic [DW-1:0] last_a, last_b;
   logic          last_a_vld, last_b_vld;

   assign hit_a = last_a_vld && (cmp_a == last_a);
   assign hit_b = last_b_vld && (cmp_b == last_b);

   // LOADA is only ever issued straight from IDLE, so its data is the live request operand.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         last_a     <= '0;
         last_b     <= '0;
         last_a_vld <= 1'b0;
         last_b_vld <= 1'b0;
      end else begin
         if (ld_a) begin
            last_a     <= cmp_a;
            last_a_vld <= 1'b1;
         end
         if (ld_b) begin
            last_b     <= ld_b_data;
            last_b_vld <= 1'b1;
         end
      end
   end
endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU request into LOADA/LOADB/execute/READOUT core commands and returns the result.
// Define ALU_SEQ_SKIP_RELOAD_EN to skip loads whose operand matches the last one loaded.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int DW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [3:0]    req_op,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [7:0]    rsp_data,
   output logic [2:0]    rsp_flags,
   output logic          rsp_err,
   output logic [3:0]    core_op,
   output logic [DW-1:0] core_data,
   input  logic [10:0]   core_result,
   output logic          busy
);
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_t        state, nxt;
   logic [DW-1:0] b_q;
   logic [3:0]    op_q;
   logic          skip_b;
   logic [2:0]    cnt;
   logic          legal, hit_a, hit_b;

   assign legal     = op_legal(req_op);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

`ifdef ALU_SEQ_SKIP_RELOAD_EN
   alu_seq_opcache #(.DW(DW)) u_opcache (
      .clk       (clk),
      .rst       (rst),
      .cmp_a     (req_a),
      .cmp_b     (req_b),
      .ld_a      (nxt == LDA),
      .ld_b      (nxt == LDB),
      .ld_b_data (state == IDLE ? req_b : b_q),
      .clr       (state == IDLE && req_valid && !legal),
      .hit_a     (hit_a),
      .hit_b     (hit_b)
   );
`else
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (req_valid) nxt = !legal ? RSP : !hit_a ? LDA : !hit_b ? LDB : EXE;
         LDA:  nxt = skip_b ? EXE : LDB;
         LDB:  nxt = EXE;
         EXE:  nxt = RDO;
         RDO:  nxt = WAIT;
         WAIT: if (cnt == 3'd0) nxt = RSP;
         RSP:  if (rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Command outputs are decoded from the state being entered so each command is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         core_op   <= OP_NOP;
         core_data <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         b_q       <= '0;
         op_q      <= OP_NOP;
         skip_b    <= 1'b0;
      end else begin
         state     <= nxt;
         core_op   <= OP_NOP;
         core_data <= '0;
         case (nxt)
            LDA: begin
               core_op   <= OP_LOADA;
               core_data <= req_a;
            end
            LDB: begin
               core_op   <= OP_LOADB;
               core_data <= (state == IDLE) ? req_b : b_q;
            end
            EXE: core_op <= (state == IDLE) ? req_op : op_q;
            RDO: begin
               core_op <= OP_READOUT;
               cnt     <= CNT_INIT;
            end
            default: ;
         endcase

         if (state == IDLE && req_valid) begin
            b_q    <= req_b;
            op_q   <= req_op;
            skip_b <= hit_b;
            if (!legal) begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_data  <= '0;
               rsp_flags <= '0;
            end
         end

         if (state == WAIT) begin
            if (cnt == 3'd0) begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= core_result[7:0];
               rsp_flags <= core_result[FLAG_C:FLAG_V];
            end else begin
               cnt <= cnt - 3'd1;
            end
         end

         if (state == RSP && rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed table, multi-cycle corner sequences and randomized requests
// checked against a request-level reference model with a behavioural ALU core.
module tb_alu_op_sequencer;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0, rsp_ready = 1'b0;
   logic [3:0]    req_op = '0;
   logic [DW-1:0] req_a = '0, req_b = '0;
   logic          req_ready, rsp_valid, rsp_err, busy;
   logic [7:0]    rsp_data;
   logic [2:0]    rsp_flags;
   logic [3:0]    core_op;
   logic [DW-1:0] core_data;
   logic [10:0]   core_result;

   logic          req_valid3 = 1'b0, rsp_ready3 = 1'b1;
   logic [3:0]    req_op3 = '0;
   logic [DW-1:0] req_a3 = '0, req_b3 = '0;
   logic          req_ready3, rsp_valid3, rsp_err3, busy3;
   logic [7:0]    rsp_data3;
   logic [2:0]    rsp_flags3;
   logic [3:0]    core_op3;
   logic [DW-1:0] core_data3;
   logic [10:0]   core_result3;

   int checks = 0, failures = 0;

   alu_op_sequencer #(.RD_LAT(1), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .core_op(core_op),
      .core_data(core_data), .core_result(core_result), .busy(busy));

   alu_op_sequencer #(.RD_LAT(3), .DW(DW)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
      .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_data(rsp_data3), .rsp_flags(rsp_flags3), .rsp_err(rsp_err3), .core_op(core_op3),
      .core_data(core_data3), .core_result(core_result3), .busy(busy3));

   // Behavioural 8-bit ALU: result {C,S,V,r}
   function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd5: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd6: r = a & b;
         4'd7: r = a | b;
         default: r = a ^ b;
      endcase
      return {c, r[7], v, r};
   endfunction

   // Core models: latch operands on loads, compute on execute, publish on READOUT.
   logic [7:0]  ca = '0, cb = '0, ca3 = '0, cb3 = '0;
   logic [10:0] cacc = '0, cres = '0, cacc3 = '0, cres3 = '0;
   assign core_result  = cres;
   assign core_result3 = cres3;
   always @(posedge clk) begin
      case (core_op)
         4'd0: ;
         4'd1: ca <= core_data[7:0];
         4'd2: cb <= core_data[7:0];
         4'd3: cres <= cacc;
         default: cacc <= alu_ref(core_op, ca, cb);
      endcase
   end
   always @(posedge clk) begin
      case (core_op3)
         4'd0: ;
         4'd1: ca3 <= core_data3[7:0];
         4'd2: cb3 <= core_data3[7:0];
         4'd3: cres3 <= cacc3;
         default: cacc3 <= alu_ref(core_op3, ca3, cb3);
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Request-level reference: which loads are needed, resulting latency and command order.
   logic [DW-1:0] m_a = '0, m_b = '0;
   bit            m_va = 1'b0, m_vb = 1'b0;
   task automatic model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int lat, output logic [31:0] seq);
      bit sa, sb;
      if (op < 4'd4) begin
         lat = 0; seq = '0; m_va = 1'b0; m_vb = 1'b0;
      end else begin
`ifdef ALU_SEQ_SKIP_RELOAD_EN
         sa = m_va && (a == m_a);
         sb = m_vb && (b == m_b);
`else
         sa = 1'b0;
         sb = 1'b0;
`endif
         seq = '0;
         if (!sa) seq = 32'h1;
         if (!sb) seq = {seq[27:0], 4'd2};
         seq = {seq[27:0], op};
         seq = {seq[27:0], 4'd3};
         lat = 5 - int'(sa) - int'(sb);
         m_a = a; m_b = b; m_va = 1'b1; m_vb = 1'b1;
      end
   endtask

   // One full transaction on dut; pend keeps a follow-up request (ADD 3,4) waiting during backpressure.
   task automatic run_txn(input string nm, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int hold, input bit pend, input int exp_lat, input logic [31:0] exp_seq,
                          input logic [7:0] exp_d, input logic [2:0] exp_f, input logic exp_e);
      int cyc;
      logic [31:0] seq;
      check({nm, ":req_ready"}, 32'(req_ready), 32'd1);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0; seq = '0;
      while (!rsp_valid && cyc < 40) begin
         if (core_op != 4'd0) begin
            seq = {seq[27:0], core_op};
            check({nm, ":core_data"}, 32'(core_data),
                  32'(core_op == 4'd1 ? a : core_op == 4'd2 ? b : '0));
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({nm, ":latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, ":core_seq"}, seq, exp_seq);
      if (pend) begin
         req_op = 4'd4; req_a = 16'h0003; req_b = 16'h0004; req_valid = 1'b1;
      end
      for (int i = 0; i <= hold; i++) begin
         check({nm, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
         check({nm, ":rsp_data"}, 32'(rsp_data), 32'(exp_d));
         check({nm, ":rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
         check({nm, ":rsp_err"}, 32'(rsp_err), 32'(exp_e));
         check({nm, ":req_ready_hold"}, 32'(req_ready), 32'd0);
         if (pend) check({nm, ":no_cmd_hold"}, 32'(core_op), 32'd0);
         if (i < hold) begin @(posedge clk); #1; end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({nm, ":rsp_clear"}, 32'(rsp_valid), 32'd0);
      check({nm, ":idle_after"}, 32'(busy), 32'd0);
      check({nm, ":no_cmd_after"}, 32'(core_op), 32'd0);
   endtask

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [7:0]  d;
      logic [2:0]  f;
      logic        e;
      int          lat;
      logic [31:0] seq;
   } vec_t;

   initial begin
      vec_t        tbl[5];
      int          lat, cyc, stale;
      logic [31:0] seq;
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [10:0] r;

      tbl[0] = '{"sub_5_10",  4'd5, 16'h0005, 16'h000A, 8'hFB, 3'b110, 1'b0, 5, 32'h1253};
      tbl[1] = '{"add_ovf",   4'd4, 16'h007F, 16'h0001, 8'h80, 3'b011, 1'b0, 5, 32'h1243};
      tbl[2] = '{"illegal_2", 4'd2, 16'h1234, 16'h5678, 8'h00, 3'b000, 1'b1, 0, 32'h0};
      tbl[3] = '{"add_carry", 4'd4, 16'h12FF, 16'h0001, 8'h00, 3'b100, 1'b0, 5, 32'h1243};
      tbl[4] = '{"and_op6",   4'd6, 16'h000F, 16'h003C, 8'h0C, 3'b000, 1'b0, 5, 32'h1263};

      repeat (2) @(posedge clk);
      #1;
      check("rst:core_op", 32'(core_op), 32'd0);
      check("rst:core_data", 32'(core_data), 32'd0);
      check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst:rsp_data", 32'(rsp_data), 32'd0);
      check("rst:rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst:rsp_err", 32'(rsp_err), 32'd0);
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         model(tbl[i].op, tbl[i].a, tbl[i].b, lat, seq);
         run_txn(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0,
                 tbl[i].lat, tbl[i].seq, tbl[i].d, tbl[i].f, tbl[i].e);
      end

      // Identical back-to-back ADDs
      model(4'd4, 16'h0011, 16'h0022, lat, seq);
      run_txn("rep_add1", 4'd4, 16'h0011, 16'h0022, 0, 1'b0, 5, 32'h1243, 8'h33, 3'b000, 1'b0);
      model(4'd4, 16'h0011, 16'h0022, lat, seq);
`ifdef ALU_SEQ_SKIP_RELOAD_EN
      run_txn("rep_add2", 4'd4, 16'h0011, 16'h0022, 0, 1'b0, 3, 32'h43, 8'h33, 3'b000, 1'b0);
`else
      run_txn("rep_add2", 4'd4, 16'h0011, 16'h0022, 0, 1'b0, 5, 32'h1243, 8'h33, 3'b000, 1'b0);
`endif

      // Backpressure with a follow-up request waiting
      model(4'd6, 16'h00F0, 16'h0FF0, lat, seq);
      run_txn("bp", 4'd6, 16'h00F0, 16'h0FF0, 10, 1'b1, lat, seq, 8'hF0, 3'b010, 1'b0);
      model(4'd4, 16'h0003, 16'h0004, lat, seq);
      run_txn("bp_next", 4'd4, 16'h0003, 16'h0004, 0, 1'b0, lat, seq, 8'h07, 3'b000, 1'b0);

      // Reset while in LDB
      req_op = 4'd4; req_a = 16'h0100; req_b = 16'h0200; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rstldb:loada", 32'(core_op), 32'd1);
      @(posedge clk); #1;
      check("rstldb:loadb", 32'(core_op), 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_va = 1'b0; m_vb = 1'b0;
      check("rstldb:core_op", 32'(core_op), 32'd0);
      check("rstldb:rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstldb:busy", 32'(busy), 32'd0);
      check("rstldb:req_ready", 32'(req_ready), 32'd1);
      stale = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rsp_valid || core_op != 4'd0) stale++;
      end
      check("rstldb:stale", 32'(stale), 32'd0);

      // RD_LAT=3 instance: response at T+7
      req_op3 = 4'd4; req_a3 = 16'h007F; req_b3 = 16'h0001; req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      cyc = 0;
      while (!rsp_valid3 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rdlat3:latency", 32'(cyc), 32'd7);
      check("rdlat3:rsp_data", 32'(rsp_data3), 32'h80);
      check("rdlat3:rsp_flags", 32'(rsp_flags3), 32'b011);
      check("rdlat3:rsp_err", 32'(rsp_err3), 32'd0);
      @(posedge clk); #1;
      check("rdlat3:idle", 32'(busy3), 32'd0);

      // Randomized requests, with operand reuse to exercise load skipping
      for (int n = 0; n < 40; n++) begin
         op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
         a  = ($urandom_range(0, 2) == 0) ? m_a : 16'($urandom);
         b  = ($urandom_range(0, 2) == 0) ? m_b : 16'($urandom);
         r  = alu_ref(op, a[7:0], b[7:0]);
         model(op, a, b, lat, seq);
         if (op < 4'd4)
            run_txn($sformatf("rnd%0d", n), op, a, b, int'($urandom_range(0, 3)), 1'b0, lat, seq, 8'h00, 3'b000, 1'b1);
         else
            run_txn($sformatf("rnd%0d", n), op, a, b, int'($urandom_range(0, 3)), 1'b0, lat, seq, r[7:0], r[10:8], 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
